// File: rtl/bridge_combine_flex_if.sv
// bridge_combine_flex_if
// Bus bundle for the bridge_combine_flex width up-converter.
// Carries both the narrow input stream and the wide output stream.
//   slave  : the packer's view (consumes vld_i/din/last_i/rdy_i, drives the rest)
//   master : the surrounding logic's view (drives beats and output ready)
// Signals:
//   vld_i, din, last_i, rdy_o        narrow input beat handshake
//   vld_o, dout, last_o, lanes_o     wide output word, rdy_i is its ready
//   word_cnt_o                       delivered-word counter (0 when stats are off)
interface bridge_combine_flex_if #(
  parameter int DATA_W = 8,
  parameter int DIN_W  = 1,
  parameter int DOUT_W = 64,
  parameter int CNT_W  = $clog2(DOUT_W / DIN_W + 1)
);
  logic                           vld_i;
  logic [DIN_W-1:0][DATA_W-1:0]   din;
  logic                           last_i;
  logic                           rdy_o;
  logic                           vld_o;
  logic [DOUT_W-1:0][DATA_W-1:0]  dout;
  logic                           last_o;
  logic [CNT_W-1:0]               lanes_o;
  logic [15:0]                    word_cnt_o;
  logic                           rdy_i;

  modport slave (
    input  vld_i, din, last_i, rdy_i,
    output rdy_o, vld_o, dout, last_o, lanes_o, word_cnt_o
  );

  modport master (
    output vld_i, din, last_i, rdy_i,
    input  rdy_o, vld_o, dout, last_o, lanes_o, word_cnt_o
  );
endinterface

// File: rtl/bridge_combine_flex.sv
// bridge_combine_flex
// Packs narrow beats (DIN_W lanes) into wide words (DOUT_W lanes).
// A word closes after RATIO beats or on last_i, unwritten slots read as zero,
// and lanes_o reports how many beats it holds. An accumulator plus an output
// register give two words of buffering so the input can keep one beat per
// cycle while the consumer stalls.
// Ports:
//   clk    rising-edge clock
//   a_rst  asynchronous active-high reset
//   bus    bridge_combine_flex_if.slave (input beats, output words, counter)
// Optional feature: define BRIDGE_COMBINE_FLEX_STATS_EN to build the 16-bit
// delivered-word counter on word_cnt_o; otherwise word_cnt_o is tied to 0.
module bridge_combine_flex #(
  parameter int DATA_W = 8,
  parameter int DIN_W  = 1,
  parameter int DOUT_W = 64,
  parameter bit BIG_EN = 1'b1,
  parameter int CNT_W  = $clog2(DOUT_W / DIN_W + 1)
) (
  input  logic                  clk,
  input  logic                  a_rst,
  bridge_combine_flex_if.slave  bus
);
  localparam int RATIO = DOUT_W / DIN_W;
  localparam int IDX_W = $clog2(RATIO);

  logic [DOUT_W-1:0][DATA_W-1:0] acc_reg;
  logic [IDX_W-1:0]              idx_reg;
  logic                          acc_full_reg;
  logic                          acc_last_reg;
  logic [CNT_W-1:0]              acc_lanes_reg;

  logic [DOUT_W-1:0][DATA_W-1:0] dout_reg;
  logic                          vld_reg;
  logic                          last_reg;
  logic [CNT_W-1:0]              lanes_reg;

  logic [DOUT_W-1:0][DATA_W-1:0] base_word;
  logic [DOUT_W-1:0][DATA_W-1:0] merged_word;
  logic                          rdy;
  logic                          in_fire;
  logic                          out_free;
  logic                          word_done;
  logic [CNT_W-1:0]              beat_lanes;

  assign rdy        = !acc_full_reg && !a_rst;
  assign in_fire    = bus.vld_i && rdy;
  assign out_free   = !vld_reg || bus.rdy_i;
  assign word_done  = in_fire && ((idx_reg == IDX_W'(RATIO - 1)) || bus.last_i);
  assign beat_lanes = CNT_W'(idx_reg) + CNT_W'(1);

  // A new word starts from all-zero so early-terminated words come out padded;
  // stale accumulator contents from the previous word are never reused.
  assign base_word = (idx_reg == '0) ? '0 : acc_reg;

  // Each slot either takes the incoming beat or keeps what is already there.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
    localparam int LO = BIG_EN ? (DOUT_W - (gi + 1) * DIN_W) : (gi * DIN_W);
    assign merged_word[LO +: DIN_W] =
      (idx_reg == IDX_W'(gi)) ? bus.din : base_word[LO +: DIN_W];
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      acc_reg       <= '0;
      idx_reg       <= '0;
      acc_full_reg  <= 1'b0;
      acc_last_reg  <= 1'b0;
      acc_lanes_reg <= '0;
      dout_reg      <= '0;
      vld_reg       <= 1'b0;
      last_reg      <= 1'b0;
      lanes_reg     <= '0;
    end else begin
      // Output handshake; a load below overrides this clear.
      if (vld_reg && bus.rdy_i) vld_reg <= 1'b0;

      if (acc_full_reg) begin
        // A parked word drains as soon as the output frees up. No beat can be
        // accepted meanwhile because rdy is low.
        if (out_free) begin
          dout_reg     <= acc_reg;
          last_reg     <= acc_last_reg;
          lanes_reg    <= acc_lanes_reg;
          vld_reg      <= 1'b1;
          acc_full_reg <= 1'b0;
          idx_reg      <= '0;
        end
      end else if (in_fire) begin
        if (word_done) begin
          if (out_free) begin
            dout_reg  <= merged_word;
            last_reg  <= bus.last_i;
            lanes_reg <= beat_lanes;
            vld_reg   <= 1'b1;
            idx_reg   <= '0;
          end else begin
            acc_reg       <= merged_word;
            acc_last_reg  <= bus.last_i;
            acc_lanes_reg <= beat_lanes;
            acc_full_reg  <= 1'b1;
          end
        end else begin
          acc_reg <= merged_word;
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  assign bus.rdy_o   = rdy;
  assign bus.vld_o   = vld_reg;
  assign bus.dout    = dout_reg;
  assign bus.last_o  = last_reg;
  assign bus.lanes_o = lanes_reg;

`ifdef BRIDGE_COMBINE_FLEX_STATS_EN
  logic [15:0] word_cnt_reg;

  // Wraps naturally from 0xFFFF to 0x0000.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      word_cnt_reg <= '0;
    end else if (vld_reg && bus.rdy_i) begin
      word_cnt_reg <= word_cnt_reg + 16'd1;
    end
  end

  assign bus.word_cnt_o = word_cnt_reg;
`else
  assign bus.word_cnt_o = '0;
`endif

endmodule
